// File: rtl/fifo_async_pkg.sv
// Shared definitions for the async FIFO and its read-side adapters.
package fifo_async_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry registered buffer; dout is always the oldest word (head).
module skid_buf2 #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] dout,
  output logic [1:0]       occ
);
  import fifo_async_pkg::*;

  logic [DSIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = din;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d = din;
            occ_d  = OCC_TWO;
          end
          2'b01: occ_d = OCC_EMPTY;
          // Simultaneous push/pop: the incoming word replaces the departing head.
          2'b11: head_d = din;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = din;
          else      occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    if (flush) occ_d = OCC_EMPTY;
  end

  assign dout = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a registered valid/ready stream with flush and a transfer counter.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] read_data,
  output logic             rq,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  input  logic             flush,
  output logic [1:0]       occ,
  output logic [CSIZE-1:0] word_cnt
);
  import fifo_async_pkg::*;

  logic pop;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid && m_ready;
  // A full buffer may still pull a word when the head leaves in the same cycle.
  assign rq      = rrst_n && !rempty && !flush && ((occ != OCC_TWO) || m_ready);

  skid_buf2 #(.DSIZE(DSIZE)) u_buf (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .push   (rq),
    .pop    (pop),
    .flush  (flush),
    .din    (read_data),
    .dout   (m_data),
    .occ    (occ)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)  word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + CSIZE'(1);
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain adapter for the async FIFO. Lives entirely in the read-clock domain. It pulls words out of the FIFO through the `rq`/`rempty`/`read_data` interface and presents them as a registered valid/ready stream (`m_valid`/`m_ready`/`m_data`) at one word per cycle. It also provides a flush and a delivered-word counter.

## Interface
Parameters:
- `DSIZE`, 8, data word width; must match the FIFO `DSIZE`.
- `CSIZE`, 16, width of the delivered-word counter.

Ports:
- `rclk`, in, 1, read-domain clock; all logic on its rising edge.
- `rrst_n`, in, 1, asynchronous active-low reset.
- `rempty`, in, 1, FIFO empty flag, synchronous to `rclk`.
- `read_data`, in, DSIZE, FIFO head word.
  - Fall-through: valid in the same cycle whenever `rempty`=0.
- `rq`, out, 1, FIFO read strobe.
  - Pops the head at the rising edge where `rq`=1.
- `m_valid`, out, 1, output stream valid.
- `m_data`, out, DSIZE, output stream data.
- `m_ready`, in, 1, downstream ready.
- `flush`, in, 1, drop all buffered words; sampled at the rising edge.
- `occ`, out, 2, current buffer occupancy (0..2).
- `word_cnt`, out, CSIZE, count of accepted stream transfers; wraps.

## Operation
- Internal 2-entry buffer, head/tail registers; `m_data` = head register.
- `m_valid` = (`occ` != 0).
- Pop: `pop` = `m_valid` && `m_ready`.
- Read strobe: `rq` = `rrst_n` && !`rempty` && !`flush` && (`occ` < 2 || `m_ready`).
  - Combinational.
  - Never asserted while `rempty`=1; underflow is impossible.
- Push: `push` = `rq`. `read_data` is captured into the buffer on that edge.
- Occupancy states and transitions:
  - EMPTY (0): push → ONE.
  - ONE (1):
    - push && !pop → TWO.
    - pop && !push → EMPTY.
    - push && pop → ONE; the new word becomes head.
  - TWO (2):
    - pop && !push → ONE.
    - pop && push → TWO.
    - A push without pop is impossible.
- Ordering: strict FIFO order; no word is duplicated or lost except by flush.
- Flush:
  - Next state EMPTY; `rq`=0 that cycle.
  - A transfer with `pop`=1 in the flush cycle still counts in `word_cnt`.
- `word_cnt`: +1 per `pop`; wraps from 2^CSIZE-1 to 0.
- `m_data` holds its value while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset values (async assert, sync release):
  - `m_valid`=0, `m_data`=0, `occ`=0, `word_cnt`=0.
  - `rq`=0 while `rrst_n`=0.
- Latency: word at `read_data` with `rq`=1 in cycle N → `m_valid`/`m_data` in cycle N+1.
- Throughput: 1 word/cycle sustained with `m_ready` held high and FIFO non-empty.
- Backpressure:
  - With `m_ready`=0, at most 2 words are pulled, then `rq` drops.
  - `rq` reasserts in the same cycle `m_ready` rises (combinational path `m_ready` → `rq`).
- Reset mid-operation: buffered words are discarded. The FIFO pointers are reset by the same `rrst_n`.
- `rempty` rising in the same cycle as `pop`: `rq`=0, occupancy decrements, no stale capture.

## Structure
- Shared package `fifo_async_pkg`: occupancy localparams `OCC_EMPTY`=0, `OCC_ONE`=1, `OCC_TWO`=2.
- One sub-module: `skid_buf2`, the 2-entry data buffer.
  - Inputs: `push`/`pop`/`flush`/`din`.
  - Outputs: `dout`/`occ`.
- Top level holds `rq` generation and `word_cnt`.
- No clock-domain crossings inside this block.

## Test plan
- Reset: assert `rrst_n`=0 mid-stream with `occ`=2 → all outputs 0 and `rq`=0 immediately; after release with `rempty`=1, outputs stay idle.
- Streaming: FIFO preloaded with 0x01..0x10, `m_ready`=1 → 16 consecutive `m_valid` cycles with data 0x01..0x10 in order, first one cycle after the first `rq`; `word_cnt`=16.
- Backpressure: `m_ready`=0 with 5 words in FIFO → exactly 2 `rq` pulses, `occ`=2, `m_data`=first word held; raise `m_ready` → remaining 3 words delivered in order, no gaps.
- Alternating `m_ready` (1,0,1,0…) over 8 words → order preserved, `occ` never >2, `word_cnt`=8.
- Flush with `occ`=2 and `m_ready`=1 in the same cycle → head word counted (`word_cnt`+1), next cycle `m_valid`=0, `rq`=0 during the flush cycle; the next FIFO word is delivered afterwards.
- Counter wrap: CSIZE=4, deliver 17 words → `word_cnt`=1.
